// File: rtl/rsa_cmd_pkg.sv
// Command codes shared by the RSA wrapper and its host-side driver, plus the
// driver's state encoding and the step-to-command mapping.
package rsa_cmd_pkg;

  localparam logic [31:0] CMD_COMPUTE_EXP = 32'h3;
  localparam logic [31:0] CMD_MOD         = 32'h5;
  localparam logic [31:0] CMD_RMOD        = 32'h6;
  localparam logic [31:0] CMD_RSQ         = 32'h7;
  localparam logic [31:0] CMD_X           = 32'h8;
  localparam logic [31:0] CMD_EXP         = 32'h9;
  localparam logic [31:0] CMD_WRITE       = 32'hA;

  localparam logic [2:0] STEP_COMPUTE = 3'd5;
  localparam logic [2:0] STEP_LAST    = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_TX_WAIT,
    S_TX_SEND,
    S_RX_WAIT,
    S_WAIT_DONE,
    S_ACK,
    S_WAIT_LOW,
    S_RES,
    S_ERR
  } drv_state_e;

  // Steps 0..4 load operands, 5 starts the exponentiation, 6 reads the result.
  function automatic logic [31:0] step_cmd(input logic [2:0] step);
    case (step)
      3'd0:    return CMD_MOD;
      3'd1:    return CMD_RMOD;
      3'd2:    return CMD_RSQ;
      3'd3:    return CMD_X;
      3'd4:    return CMD_EXP;
      3'd5:    return CMD_COMPUTE_EXP;
      default: return CMD_WRITE;
    endcase
  endfunction

endpackage

// File: rtl/rsa_host_driver.sv
// Hardware initiator for the RSA wrapper: runs one modular exponentiation job
// through the load / compute / write-back command sequence and returns the result.
module rsa_host_driver
  import rsa_cmd_pkg::*;
#(
  parameter int TX_SIZE   = 1024,
  parameter int TIMEOUT_W = 24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [TX_SIZE-1:0] job_mod,
  input  logic [TX_SIZE-1:0] job_rmod,
  input  logic [TX_SIZE-1:0] job_rsq,
  input  logic [TX_SIZE-1:0] job_x,
  input  logic [TX_SIZE-1:0] job_exp,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TX_SIZE-1:0] res_data,
  output logic               res_error,
  output logic [31:0]        cmd,
  output logic               cmd_valid,
  input  logic               done,
  output logic               done_read,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [TX_SIZE-1:0] tx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [TX_SIZE-1:0] rx_data,
  output drv_state_e         state
);

  // Handshakes: a job transfers on a cycle with job_valid && job_ready, a result
  // on res_valid && res_ready, and a wrapper result word on rx_valid && rx_ready.
  // tx_valid and cmd_valid are single-cycle strobes, and done_read acknowledges
  // one rising done; done must be seen low again before the next command.

  drv_state_e         state_q, state_n;
  logic [2:0]         step_q, step_n;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_inc;
  logic               waiting;
  logic [TX_SIZE-1:0] mod_q, rmod_q, rsq_q, x_q, exp_q, result_q, op_sel;

  assign tmo_inc  = tmo_q + 1'b1;
  assign rx_ready = (state_q == S_RX_WAIT) && rx_valid;
  assign state    = state_q;

  always_comb begin
    op_sel = mod_q;
    case (step_q)
      3'd1:    op_sel = rmod_q;
      3'd2:    op_sel = rsq_q;
      3'd3:    op_sel = x_q;
      3'd4:    op_sel = exp_q;
      default: op_sel = mod_q;
    endcase
  end

  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    waiting = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          state_n = S_CMD;
          step_n  = 3'd0;
        end
      end
      S_CMD: begin
        if (step_q < STEP_COMPUTE)       state_n = S_TX_WAIT;
        else if (step_q == STEP_COMPUTE) state_n = S_WAIT_DONE;
        else                             state_n = S_RX_WAIT;
      end
      S_TX_WAIT: begin
        waiting = 1'b1;
        if (tx_ready) state_n = S_TX_SEND;
      end
      S_TX_SEND: state_n = S_WAIT_DONE;
      S_RX_WAIT: begin
        waiting = 1'b1;
        if (rx_valid) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        waiting = 1'b1;
        if (done) state_n = S_ACK;
      end
      S_ACK: state_n = S_WAIT_LOW;
      S_WAIT_LOW: begin
        waiting = 1'b1;
        if (!done) begin
          if (step_q < STEP_LAST) begin
            step_n  = step_q + 3'd1;
            state_n = S_CMD;
          end else begin
            state_n = S_RES;
          end
        end
      end
      S_RES:   if (res_ready) state_n = S_IDLE;
      S_ERR:   if (res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Forward progress wins over a timeout landing on the same cycle.
    if (waiting && (state_n == state_q) && (tmo_inc == {TIMEOUT_W{1'b1}}))
      state_n = S_ERR;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      tmo_q     <= '0;
      job_ready <= 1'b0;
      res_valid <= 1'b0;
      res_error <= 1'b0;
      res_data  <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      done_read <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state_q   <= state_n;
      step_q    <= step_n;
      if (state_n != state_q) tmo_q <= '0;
      else if (waiting)       tmo_q <= tmo_inc;
      job_ready <= (state_n == S_IDLE);
      res_valid <= (state_n == S_RES) || (state_n == S_ERR);
      res_error <= (state_n == S_ERR);
      res_data  <= (state_n == S_RES) ? result_q : '0;
      cmd_valid <= (state_n == S_CMD);
      cmd       <= (state_n == S_CMD) ? step_cmd(step_n) : '0;
      done_read <= (state_n == S_ACK);
      tx_valid  <= (state_n == S_TX_SEND);
      tx_data   <= (state_n == S_TX_SEND) ? op_sel : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && job_valid && job_ready) begin
      mod_q  <= job_mod;
      rmod_q <= job_rmod;
      rsq_q  <= job_rsq;
      x_q    <= job_x;
      exp_q  <= job_exp;
    end
    if (rx_ready) result_q <= rx_data;
  end

endmodule

// File: doc/rsa_host_driver.md
# rsa_host_driver

Hardware initiator for the Arm-to-FPGA RSA command/data protocol. It plays the Arm's role: takes one exponentiation job (modulus, R mod m, R² mod m, base x, exponent), issues the load, compute and write-back command sequence to the RSA wrapper, and returns the 1024-bit result. It is used for on-chip self-test and for host-less operation, and as the stimulus engine in wrapper-level benches.

## Interface
- TX_SIZE, 1024: data word width; each word packs two 512-bit operands (core 2 in [1023:512], core 1 in [511:0]), passed through unchanged.
- TIMEOUT_W, 24: width of the per-wait timeout counter.
- clk in 1: rising-edge clock.
- resetn in 1: reset; synchronous, active-low.
- job_valid in 1: job offer.
- job_ready out 1: driver idle; a job is accepted when job_valid && job_ready.
- job_mod, job_rmod, job_rsq, job_x, job_exp in TX_SIZE each: operands, captured on acceptance.
- res_valid out 1: result or error available.
- res_ready in 1: consumer accepts the result.
- res_data out TX_SIZE: result word; 0 on error.
- res_error out 1: timeout occurred. Valid with res_valid.
- cmd out 32: command code.
- cmd_valid out 1: one-cycle command strobe.
- done in 1: wrapper done.
- done_read out 1: one-cycle done acknowledge.
- tx_valid out 1: data to wrapper valid.
- tx_ready in 1: wrapper ready for data.
- tx_data out TX_SIZE: data to wrapper.
- rx_valid in 1: wrapper result valid.
- rx_ready out 1: driver accepts the result word.
- rx_data in TX_SIZE: result word from wrapper.

## Operation
- Command codes: MOD=5, RMOD=6, RSQ=7, X=8, EXP=9, COMPUTE_EXP=3, WRITE=0xA.
- The step counter (0..6) walks MOD, RMOD, RSQ, X, EXP, COMPUTE_EXP, WRITE in that order.
- States:
  - IDLE: job_ready=1. On acceptance, register the five operands, set step=0, and go to CMD.
  - CMD: drive cmd=code(step) and cmd_valid=1 for exactly one cycle. Steps 0-4 go to TX_WAIT, step 5 goes to WAIT_DONE, and step 6 goes to RX_WAIT.
  - TX_WAIT: wait for tx_ready=1, then go to TX_SEND.
  - TX_SEND: tx_valid=1 and tx_data=operand(step) for exactly one cycle, then go to WAIT_DONE.
  - RX_WAIT: wait for rx_valid=1. In that same cycle drive rx_ready=1 (combinational) and capture rx_data into the result register, then go to WAIT_DONE.
  - WAIT_DONE: wait for done=1, then go to ACK.
  - ACK: done_read=1 for one cycle, then go to WAIT_LOW.
  - WAIT_LOW: wait for done=0. The wrapper's done lags its state by one cycle, so this prevents a double acknowledge. Then, if step<6, increment step and go to CMD; otherwise go to RES.
  - RES: res_valid=1 and res_error=0. Hold until res_ready, then go to IDLE.
  - ERR: res_valid=1, res_error=1, res_data=0. Hold until res_ready, then go to IDLE.
- Timeout counter:
  - Clears on every state entry.
  - Increments each cycle spent in TX_WAIT, RX_WAIT, WAIT_DONE or WAIT_LOW.
  - Reaching all-ones forces ERR.
- tx_data is 0 whenever tx_valid=0.

## Timing
- Every output is 0 during reset: job_ready, res_valid, res_error, res_data, cmd, cmd_valid, done_read, tx_valid, tx_data, rx_ready. All are registered except rx_ready.
- job_ready rises the first cycle after resetn goes high.
- tx_valid is never asserted in the same cycle tx_ready first rises; there is a minimum one-cycle gap.
- Load step against a wrapper with registered ready/done takes 8 cycles from cmd_valid to the next cmd_valid:
  - cmd, ready+1, send, done+1, ack, done low, next cmd.
- Minimum job-to-res_valid latency is 7 steps plus the compute time.
- Reset mid-job returns to IDLE, drops all strobes and discards the job. The wrapper must be reset alongside.
- Holding res_ready high makes res_valid a single-cycle pulse.
- job_valid is ignored outside IDLE.

## Structure
- Shared package rsa_cmd_pkg holds the command code constants, which are shared with the wrapper, and the driver state enum.
- No sub-module. The timeout counter and the step sequencer are inline.

## Test plan
- Behavioural wrapper model with 3-cycle compute returning 0xDEAD…BEEF.
  - Required: cmd sequence 5,6,7,8,9,3,A; each cmd_valid is exactly one cycle; res_data=0xDEAD…BEEF; res_error=0.
- Operand routing: job_x=0x11…11, others distinct.
  - Required: tx_data=0x11…11 exactly on the step-3 tx_valid cycle; tx_data=0 at all other times.
- Done lag: model holds done high 2 cycles after done_read.
  - Required: exactly one done_read per step; 7 in total.
- Timeout with TIMEOUT_W=4: model never raises done after COMPUTE_EXP.
  - Required: ERR entered 15 cycles into WAIT_DONE; res_valid=1, res_error=1, res_data=0.
- Reset asserted during TX_WAIT of step 2.
  - Required: all outputs 0 next cycle; job_ready=1 one cycle after release; a new job completes normally.
- res_ready held low for 10 cycles.
  - Required: res_valid and res_data stable; job_ready=0 until res_ready is taken.
